reg_file_2w_sb: RTL and testbench
=================================

REG_FILE_2W_SB -- requirements
Module: reg_file_2w_sb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and of all data ports.
REQ-002 Parameter ADDR_WIDTH, default 5, address width; register count NUM = 2**ADDR_WIDTH.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 reads as 0 and is never written or marked busy.
REQ-004 Timing: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 raddr1, raddr2  input  ADDR_WIDTH  read addresses, ports 1 and 2.
REQ-008 rdata1, rdata2  output  DATA_WIDTH  combinational read data, ports 1 and 2.
REQ-009 rbusy1, rbusy2  output  1  combinational busy flag of the addressed register.
REQ-010 wen0, wen1  input  1  write enables, write ports 0 and 1.
REQ-011 waddr0, waddr1  input  ADDR_WIDTH  write addresses.
REQ-012 wdata0, wdata1  input  DATA_WIDTH  write data.
REQ-013 set_en  input  1  marks register set_addr busy (pending producer issued).
REQ-014 set_addr  input  ADDR_WIDTH  register to mark busy.
REQ-015 busy_cnt  output  ADDR_WIDTH+1  registered count of busy registers.

Function
REQ-016 Storage: NUM x DATA_WIDTH array plus NUM-bit scoreboard sb.
REQ-017 Write: when wenN=1 and rst=0, register waddrN takes wdataN at the clock edge; array value is visible from the next cycle.
REQ-018 Write conflict: wen0=wen1=1 with waddr0==waddr1 -> port 1 data stored, port 0 data discarded.
REQ-019 ZERO_REG=1: writes and set_en to address 0 are ignored; rdata for address 0 = 0, rbusy = 0, regardless of bypass.
REQ-020 Bypass: if wen1=1 and waddr1==raddrK, rdataK = wdata1; else if wen0=1 and waddr0==raddrK, rdataK = wdata0; else array value (same-cycle, zero latency).
REQ-021 Scoreboard set: set_en=1 sets sb[set_addr] at the clock edge.
REQ-022 Scoreboard clear: any accepted write to address A clears sb[A] at the clock edge.
REQ-023 Set/clear same cycle, same address: set wins; sb[A]=1 afterwards.
REQ-024 rbusyK = sb[raddrK] AND NOT (an accepted write to raddrK this cycle); set_en in the current cycle does not affect rbusy until next cycle.
REQ-025 busy_cnt = population count of sb after each edge; never exceeds NUM (NUM-1 when ZERO_REG=1).
REQ-026 Setting an already-busy register or writing a non-busy register does not change busy_cnt.
REQ-027 No wrap-around: addresses are full-range; no illegal address exists.

Reset
REQ-028 rst=1 at a clock edge: all NUM registers = 0, sb = 0, busy_cnt = 0.
REQ-029 wen0, wen1, set_en asserted in a reset cycle have no effect on stored state.
REQ-030 During rst=1, read ports remain combinational: bypass still applies to rdata; rbusy reflects pre-reset sb until the edge.
REQ-031 Reset mid-operation discards all pending busy marks; no further action required.

Verification
REQ-032 Reset, then read all 32 addresses -> rdata=0, rbusy=0, busy_cnt=0.
REQ-033 wen0=1, waddr0=5, wdata0=0xDEADBEEF, raddr1=5 same cycle -> rdata1=0xDEADBEEF that cycle and after; next cycle with wen0=0 still 0xDEADBEEF.
REQ-034 wen0=wen1=1, waddr0=waddr1=7, wdata0=0x11, wdata1=0x22 -> rdata for 7 = 0x22 same cycle and next.
REQ-035 set_en=1 set_addr=3 -> next cycle rbusy1(raddr1=3)=1, busy_cnt=1; then wen1=1 waddr1=3 -> rbusy1=0 that cycle, busy_cnt=0 next.
REQ-036 Same cycle set_en=1 set_addr=9 and wen0=1 waddr0=9 -> sb[9]=1, busy_cnt=1 next cycle; write data 0x9 stored.
REQ-037 wen0=1 waddr0=0 wdata0=0xFFFF, set_en=1 set_addr=0, raddr2=0 -> rdata2=0, rbusy2=0, busy_cnt unchanged; rst mid-sequence with 4 busy registers -> busy_cnt=0 next cycle.

Source files
------------

// File: rtl/reg_file_2w_sb.sv
// reg_file_2w_sb: 2-read/2-write register file with write bypass and busy scoreboard
module reg_file_2w_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  rbusy1,
  output logic                  rbusy2,
  input  logic                  wen0,
  input  logic                  wen1,
  input  logic [ADDR_WIDTH-1:0] waddr0,
  input  logic [ADDR_WIDTH-1:0] waddr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  output logic [ADDR_WIDTH:0]   busy_cnt
);
  localparam int NUM = 2**ADDR_WIDTH;
  localparam bit ZR = ZERO_REG != 0;
  logic [DATA_WIDTH-1:0] mem [NUM];
  logic [NUM-1:0] sb, sb_n;
  logic [ADDR_WIDTH:0] cnt_n;
  logic we0, we1, se;
  assign we0 = wen0 && !rst && !(ZR && waddr0 == '0);
  assign we1 = wen1 && !rst && !(ZR && waddr1 == '0);
  assign se  = set_en && !rst && !(ZR && set_addr == '0);
  assign rdata1 = (ZR && raddr1 == '0) ? '0 :
                  (wen1 && waddr1 == raddr1) ? wdata1 :
                  (wen0 && waddr0 == raddr1) ? wdata0 : mem[raddr1];
  assign rdata2 = (ZR && raddr2 == '0) ? '0 :
                  (wen1 && waddr1 == raddr2) ? wdata1 :
                  (wen0 && waddr0 == raddr2) ? wdata0 : mem[raddr2];
  assign rbusy1 = sb[raddr1] && !((we0 && waddr0 == raddr1) || (we1 && waddr1 == raddr1));
  assign rbusy2 = sb[raddr2] && !((we0 && waddr0 == raddr2) || (we1 && waddr1 == raddr2));
  always_comb begin
    sb_n = sb;
    if (we0) sb_n[waddr0] = 1'b0;
    if (we1) sb_n[waddr1] = 1'b0;
    if (se) sb_n[set_addr] = 1'b1;
    cnt_n = '0;
    for (int i = 0; i < NUM; i++) cnt_n = cnt_n + (ADDR_WIDTH+1)'(sb_n[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) mem[i] <= '0;
      sb <= '0;
      busy_cnt <= '0;
    end else begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
      sb <= sb_n;
      busy_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_reg_file_2w_sb.sv
// tb_reg_file_2w_sb: scoreboard-driven self-checking bench for reg_file_2w_sb
module tb_reg_file_2w_sb;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] raddr1 = '0, raddr2 = '0, waddr0 = '0, waddr1 = '0, set_addr = '0;
  logic [31:0] rdata1, rdata2, wdata0 = '0, wdata1 = '0;
  logic rbusy1, rbusy2, wen0 = 1'b0, wen1 = 1'b0, set_en = 1'b0;
  logic [5:0] busy_cnt;
  logic [31:0] m [32];
  logic [31:0] msb = '0;
  logic [63:0] exp_q [$];
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  reg_file_2w_sb dut (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .rbusy1(rbusy1), .rbusy2(rbusy2), .wen0(wen0), .wen1(wen1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .set_en(set_en), .set_addr(set_addr), .busy_cnt(busy_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mrd(input logic [4:0] a);
    if (a == 0) return 0;
    if (wen1 && waddr1 == a) return wdata1;
    if (wen0 && waddr0 == a) return wdata0;
    return m[a];
  endfunction
  function automatic logic mbusy(input logic [4:0] a);
    logic wr;
    wr = !rst && ((wen0 && waddr0 == a) || (wen1 && waddr1 == a));
    return msb[a] && !wr;
  endfunction
  task automatic settle();
    exp_q.push_back(64'(mrd(raddr1)));
    exp_q.push_back(64'(mrd(raddr2)));
    exp_q.push_back(64'(mbusy(raddr1)));
    exp_q.push_back(64'(mbusy(raddr2)));
    #2;
    chk("rdata1", 64'(rdata1), exp_q.pop_front());
    chk("rdata2", 64'(rdata2), exp_q.pop_front());
    chk("rbusy1", 64'(rbusy1), exp_q.pop_front());
    chk("rbusy2", 64'(rbusy2), exp_q.pop_front());
  endtask
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) m[i] = 0;
      msb = 0;
    end else begin
      if (wen0 && waddr0 != 0) begin m[waddr0] = wdata0; msb[waddr0] = 1'b0; end
      if (wen1 && waddr1 != 0) begin m[waddr1] = wdata1; msb[waddr1] = 1'b0; end
      if (set_en && set_addr != 0) msb[set_addr] = 1'b1;
    end
    exp_q.push_back(64'($countones(msb)));
    @(posedge clk);
    #1;
    chk("busy_cnt", 64'(busy_cnt), exp_q.pop_front());
  endtask
  task automatic idle();
    rst = 0; wen0 = 0; wen1 = 0; set_en = 0;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) m[i] = 0;
    rst = 1;
    tick();
    idle();
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      settle();
      chk("reset_rdata", 64'(rdata1), 0);
    end
    chk("reset_cnt", 64'(busy_cnt), 0);
    wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; raddr1 = 5;
    settle();
    chk("byp_w0", 64'(rdata1), 64'hDEADBEEF);
    tick();
    wen0 = 0;
    settle();
    chk("stored_w0", 64'(rdata1), 64'hDEADBEEF);
    wen0 = 1; wen1 = 1; waddr0 = 7; waddr1 = 7; wdata0 = 32'h11; wdata1 = 32'h22; raddr2 = 7;
    settle();
    chk("conflict_byp", 64'(rdata2), 64'h22);
    tick();
    idle();
    settle();
    chk("conflict_store", 64'(rdata2), 64'h22);
    set_en = 1; set_addr = 3; raddr1 = 3;
    settle();
    chk("set_no_byp", 64'(rbusy1), 0);
    tick();
    idle();
    settle();
    chk("set_busy", 64'(rbusy1), 1);
    chk("set_cnt", 64'(busy_cnt), 1);
    wen1 = 1; waddr1 = 3; wdata1 = 32'h33;
    settle();
    chk("clr_busy", 64'(rbusy1), 0);
    tick();
    chk("clr_cnt", 64'(busy_cnt), 0);
    idle();
    set_en = 1; set_addr = 9; wen0 = 1; waddr0 = 9; wdata0 = 32'h9;
    tick();
    idle(); raddr1 = 9;
    settle();
    chk("setwin_busy", 64'(rbusy1), 1);
    chk("setwin_cnt", 64'(busy_cnt), 1);
    chk("setwin_data", 64'(rdata1), 9);
    wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFF; set_en = 1; set_addr = 0; raddr2 = 0;
    settle();
    chk("zero_rdata", 64'(rdata2), 0);
    chk("zero_rbusy", 64'(rbusy2), 0);
    tick();
    chk("zero_cnt", 64'(busy_cnt), 1);
    idle();
    for (int a = 1; a < 4; a++) begin
      set_en = 1; set_addr = 5'(a);
      tick();
    end
    idle();
    chk("four_busy", 64'(busy_cnt), 4);
    rst = 1; wen0 = 1; waddr0 = 12; wdata0 = 32'hABCD; set_en = 1; set_addr = 13; raddr1 = 12; raddr2 = 2;
    settle();
    chk("rst_byp", 64'(rdata1), 64'hABCD);
    chk("rst_prebusy", 64'(rbusy2), 1);
    tick();
    chk("rst_cnt", 64'(busy_cnt), 0);
    idle();
    settle();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      wen0 = 1'($urandom_range(0, 1)); wen1 = 1'($urandom_range(0, 1));
      set_en = 1'($urandom_range(0, 1));
      waddr0 = 5'($urandom_range(0, 7)); waddr1 = 5'($urandom_range(0, 7));
      set_addr = 5'($urandom_range(0, 7));
      raddr1 = 5'($urandom_range(0, 7)); raddr2 = 5'($urandom_range(0, 31));
      wdata0 = $urandom; wdata1 = $urandom;
      settle();
      tick();
    end
    if (exp_q.size() != 0) chk("queue_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
